inv_key_sched: RTL and testbench
================================

# inv_key_sched

Sequential AES-128 inverse key-schedule engine for the decryption datapath. It accepts the final (round-10) round key and walks the key expansion backwards, one round per accepted transfer. It streams round keys 10, 9, …, 0 to the inverse cipher over a valid/ready handshake. The block sits beside `roundKey`, which expands forward; this block is the reverse direction of the same schedule, so decryption needs no stored expanded key table.

## Interface
Parameters: none (AES-128 only; 11 round keys, fixed).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  load request; sampled only in IDLE
- key_in  in  128  round-10 key, byte 0 = bits [127:120]; sampled on the accepted start cycle
- out_ready  in  1  consumer ready
- key_valid  out  1  key_out/round_out hold a valid key
- key_out  out  128  current round key, same byte order as key_in
- round_out  out  4  round index of key_out (10 down to 0)
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the round-0 key is accepted

## Operation
- Words: current key = w0‖w1‖w2‖w3 (w0 = bits [127:96]); current round index r.
- Previous-round key:
  - p3 = w3^w2
  - p2 = w2^w1
  - p1 = w1^w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {Rcon[r],24'h0}
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36. S-box is the forward AES S-box, implemented combinationally.
- States:
  - IDLE: busy=0, key_valid=0. start=1 → load key_in into the key register, r=10, go to STREAM.
  - STREAM: key_valid=1, key_out driven from the register, round_out=r.
    - Handshake (key_valid&&out_ready) with r>0 → register ← previous-round key, r ← r−1, stay in STREAM.
    - Handshake with r=0 → go to DONE.
  - DONE: done=1, key_valid=0, busy=1 for exactly one cycle → IDLE.
- out_ready low in STREAM: key_out, round_out and key_valid hold unchanged. No key is skipped or duplicated.
- start outside IDLE: ignored, no effect.
- r is 4-bit and never wraps below 0. The round-0 handshake always exits STREAM.
- key_in is don't-care except on the accepted start cycle.

## Timing
- Reset values: key_valid=0, key_out=0, round_out=0, busy=0, done=0, state=IDLE. All registers clear asynchronously.
- Start latency: start accepted at edge N → key_valid=1 with round-10 key after edge N (visible in cycle N+1). busy rises in the same cycle.
- Throughput: one key per cycle while out_ready=1. The 11 keys take 11 consecutive cycles, and done pulses in the cycle after the last handshake.
- Minimum start-to-done: 12 cycles with out_ready tied high. The next start is accepted in the cycle after done.
- rst asserted mid-stream: outputs return to reset values immediately (asynchronous). The partial sequence is abandoned, and done does not pulse.
- rst and start both high: rst wins.
- key_out is a registered value, optionally followed by a combinational InvMixColumns (see Configuration). There is no path from key_in or out_ready to key_out.

## Configuration
- Macro: INV_KEY_SCHED_EQUIV_EN.
- Defined:
  - key_out = InvMixColumns(register) for r in 1..9. This gives the equivalent inverse cipher keys (FIPS-197 §5.3.5).
  - Rounds 10 and 0 are output unchanged.
  - The internal register always holds the raw key, so the backward recursion is unaffected.
  - Latency and handshake are identical.
- Undefined: key_out = raw round key for all rounds, and no InvMixColumns logic is present.

## Test plan
- FIPS-197 A.1 stream, macro off:
  - Stimulus: reset, then start with key_in=d014f9a8c9ee2589e13f0cc8b6630ca6, out_ready=1.
  - Required response: round 10 = key_in, then ac7766f319fadc2128d12941575c006e, …, then round 3 = 3d80477d4716fe3e1e237e446d7a883b, round 2 = f2c295f27a96b9435935807a7359f67f, round 1 = a0fafe1788542cb123a339392a6c7605, round 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - Also: done pulses once, 12 cycles after start.
- Back-pressure:
  - Stimulus: same key, out_ready toggled pseudo-randomly.
  - Required response: identical 11-key sequence. key_out and round_out stay stable whenever key_valid&&!out_ready.
- Start while busy:
  - Stimulus: start pulses with key_in=0 during STREAM.
  - Required response: ignored, sequence unchanged.
- Reset mid-operation:
  - Stimulus: rst asserted at round_out=5.
  - Required response: key_valid=0, key_out=0, busy=0 immediately, no done.
  - Follow-up: a fresh start reproduces the full A.1 sequence.
- Back-to-back runs:
  - Stimulus: start the cycle after done, with key_in=0.
  - Required response: round 0 output is the expected all-zero-derived key, 62636363626363636263636362636363 at round 1 → 0 at round 0.
- Macro on:
  - Stimulus: the A.1 stream.
  - Required response: rounds 10 and 0 unchanged. Rounds 9..1 equal the bench model's InvMixColumns of the raw keys, e.g. round 1 = InvMixColumns(a0fafe1788542cb123a339392a6c7605).

Source files
------------

// File: rtl/inv_key_sched.sv
// AES-128 inverse key schedule: streams round keys 10..0 from the round-10 key.
// Define INV_KEY_SCHED_EQUIV_EN to emit equivalent-inverse-cipher keys for rounds 9..1.
module inv_key_sched (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         out_ready,
    output logic         key_valid,
    output logic [127:0] key_out,
    output logic [3:0]   round_out,
    output logic         busy,
    output logic         done
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } state_t;

    state_t       r_state;
    logic [127:0] r_key;
    logic [3:0]   r_round;
    logic         r_valid;
    logic         r_busy;
    logic         r_done;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_p0, w_p1, w_p2, w_p3;
    logic [127:0] w_prev;

    function automatic logic [7:0] sub_byte(input logic [7:0] x);
        return SBOX[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sub_byte(x[31:24]), sub_byte(x[23:16]),
                sub_byte(x[15:8]), sub_byte(x[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    assign w_w0 = r_key[127:96];
    assign w_w1 = r_key[95:64];
    assign w_w2 = r_key[63:32];
    assign w_w3 = r_key[31:0];

    // Undo one forward expansion step: w[i] = w[i-4] ^ f(w[i-1])
    assign w_p3 = w_w3 ^ w_w2;
    assign w_p2 = w_w2 ^ w_w1;
    assign w_p1 = w_w1 ^ w_w0;
    assign w_p0 = w_w0 ^ sub_word({w_p3[23:0], w_p3[31:24]})
                ^ {rcon(r_round), 24'h0};
    assign w_prev = {w_p0, w_p1, w_p2, w_p3};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_key   <= '0;
            r_round <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_key   <= key_in;
                        r_round <= 4'd10;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (r_valid && out_ready) begin
                        if (r_round != 4'd0) begin
                            r_key   <= w_prev;
                            r_round <= r_round - 4'd1;
                        end else begin
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef INV_KEY_SCHED_EQUIV_EN
    logic [127:0] w_mix;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m2 [4];
        logic [7:0] m4 [4];
        logic [7:0] m8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            m2[i] = xt(a[i]);
            m4[i] = xt(m2[i]);
            m8[i] = xt(m4[i]);
            m9[i] = m8[i] ^ a[i];
            mb[i] = m8[i] ^ m2[i] ^ a[i];
            md[i] = m8[i] ^ m4[i] ^ a[i];
            me[i] = m8[i] ^ m4[i] ^ m2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Register stays raw so the recursion is unaffected; mixing is output-only
    assign w_mix = {inv_mix_col(w_w0), inv_mix_col(w_w1),
                    inv_mix_col(w_w2), inv_mix_col(w_w3)};
    assign key_out = (r_round != 4'd0 && r_round != 4'd10) ? w_mix : r_key;
`else
    assign key_out = r_key;
`endif

    assign key_valid = r_valid;
    assign round_out = r_round;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_inv_key_sched.sv
// Scoreboard bench for inv_key_sched; reference keys come from forward expansion.
// Honours INV_KEY_SCHED_EQUIV_EN to expect equivalent-inverse keys.
module tb_inv_key_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         out_ready;
    logic         key_valid;
    logic [127:0] key_out;
    logic [3:0]   round_out;
    logic         busy;
    logic         done;

    inv_key_sched dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .out_ready (out_ready),
        .key_valid (key_valid),
        .key_out   (key_out),
        .round_out (round_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] A1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam int LIMIT = 400;

    typedef struct packed {
        logic [127:0] k;
        logic [3:0]   r;
    } exp_t;

    exp_t         sbq [$];
    logic [7:0]   sb [256];
    logic [127:0] rk_exp [11];
    int           n_chk = 0;
    int           n_pass = 0;
    int           done_cnt = 0;
    bit           prev_stall = 1'b0;
    logic [127:0] prev_k;
    logic [3:0]   prev_r;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] k);
        logic [7:0]   a [4];
        logic [7:0]   m [4];
        logic [7:0]   b;
        logic [127:0] o;
        m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) a[i] = k[127-32*c-8*i -: 8];
            for (int i = 0; i < 4; i++) begin
                b = 8'h00;
                for (int j = 0; j < 4; j++) b = b ^ gmul(a[j], m[(j-i+4)%4]);
                o[127-32*c-8*i -: 8] = b;
            end
        end
        return o;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int v = 1; v < 256; v++)
                if (gmul(x[7:0], v[7:0]) == 8'h01) inv = v[7:0];
            sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] ck);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = ck[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            rk_exp[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] exp_out(input int r);
`ifdef INV_KEY_SCHED_EQUIV_EN
        if (r >= 1 && r <= 9) return inv_mix(rk_exp[r]);
`endif
        return rk_exp[r];
    endfunction

    task automatic push_all();
        exp_t e;
        for (int r = 10; r >= 0; r--) begin
            e.k = exp_out(r);
            e.r = 4'(r);
            sbq.push_back(e);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            if (done) begin
                done_cnt++;
                check("done_flags", {126'b0, key_valid, busy}, 128'b01);
            end
            if (key_valid) check("busy_in_stream", {127'b0, busy}, 128'b1);
            if (prev_stall) begin
                check("hold_key", key_out, prev_k);
                check("hold_round", {124'b0, round_out}, {124'b0, prev_r});
                check("hold_valid", {127'b0, key_valid}, 128'b1);
            end
            if (key_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    $display("FAIL spurious_key: got round %0d key %h expected none",
                             round_out, key_out);
                end else begin
                    e = sbq.pop_front();
                    check($sformatf("key_r%0d", e.r), key_out, e.k);
                    check("round_idx", {124'b0, round_out}, {124'b0, e.r});
                end
            end
            prev_stall = key_valid && !out_ready;
            prev_k     = key_out;
            prev_r     = round_out;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic run(input logic [127:0] ck, input bit rnd_ready,
                       input bit noise, input bit chk_lat);
        int d0;
        int lat;
        expand(ck);
        push_all();
        d0 = done_cnt;
        out_ready = 1'b1;
        key_in = rk_exp[10];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        while (done_cnt == d0 && lat < LIMIT) begin
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                key_in = '0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check("run_timeout", {127'b0, lat < LIMIT}, 128'b1);
        if (chk_lat) check("start_to_done", 128'(lat), 128'd12);
        check("done_width", {127'b0, done}, 128'b0);
        check("drained", 128'(sbq.size()), 128'd0);
        sbq.delete();
    endtask

    initial begin
        int w;
        int d0;
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        key_in = '0;
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {127'b0, key_valid}, 128'b0);
        check("rst_key", key_out, 128'b0);
        check("rst_round", {124'b0, round_out}, 128'b0);
        check("rst_busy", {127'b0, busy}, 128'b0);
        check("rst_done", {127'b0, done}, 128'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        expand(128'h0);
        check("model_zero_r1", rk_exp[1], 128'h62636363626363636263636362636363);
        expand(A1_KEY);
        check("model_a1_r10", rk_exp[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("model_a1_r9", rk_exp[9], 128'hac7766f319fadc2128d12941575c006e);
        check("model_a1_r3", rk_exp[3], 128'h3d80477d4716fe3e1e237e446d7a883b);
        check("model_a1_r2", rk_exp[2], 128'hf2c295f27a96b9435935807a7359f67f);
        check("model_a1_r1", rk_exp[1], 128'ha0fafe1788542cb123a339392a6c7605);

        run(A1_KEY, 1'b0, 1'b0, 1'b1);
        run(A1_KEY, 1'b1, 1'b1, 1'b0);

        // Abort a stream at round 5 with an asynchronous reset
        expand(A1_KEY);
        push_all();
        out_ready = 1'b1;
        key_in = rk_exp[10];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        w = 0;
        while (!(key_valid && round_out == 4'd5) && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("reach_round5", {127'b0, w < 50}, 128'b1);
        d0 = done_cnt;
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst_valid", {127'b0, key_valid}, 128'b0);
        check("arst_key", key_out, 128'b0);
        check("arst_busy", {127'b0, busy}, 128'b0);
        check("arst_round", {124'b0, round_out}, 128'b0);
        sbq.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("no_done_after_rst", 128'(done_cnt), 128'(d0));
        check("idle_after_rst", {127'b0, busy}, 128'b0);
        run(A1_KEY, 1'b0, 1'b0, 1'b1);

        run(A1_KEY, 1'b0, 1'b0, 1'b1);
        run(128'h0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 5; i++)
            run({$urandom, $urandom, $urandom, $urandom}, 1'b1, i[0], 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
